// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo up/down counter family.
//   MODE_*            : encodings of the 2-bit mode input
//   presc_width()     : register width needed to count 0..PRESCALE-1
package cnt_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  // Never returns less than 1 so a PRESCALE of 1 still gets a legal vector.
  function automatic int unsigned presc_width(int unsigned presc);
    return (presc <= 1) ? 1 : $clog2(presc);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler producing one count tick every PRESCALE enabled clock cycles.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   en      : advance the phase counter this cycle
//   sclr    : synchronous return of the phase counter to 0 (wins over en)
//   tick    : combinational, high on the enabled cycle that ends a period
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sclr,
  output logic tick
);
  import cnt_pkg::*;

  localparam int unsigned PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] PhaseLast = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;

  // With PRESCALE = 1 the phase stays at 0 and every enabled cycle ticks.
  assign tick = en && (phase_q == PhaseLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else if (sclr) begin
      phase_q <= '0;
    end else if (en) begin
      phase_q <= tick ? '0 : phase_q + 1'b1;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Fully synchronous modulo-MOD counter with prescaler, up/down/ping-pong/hold
// modes, synchronous clear, clamped parallel load, terminal-count pulse and a
// sticky wrap flag.
// Ports:
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   en           : count enable (gates prescaler and ticks)
//   clear        : synchronous clear of q, prescaler, dir, tc and wrap_flag
//   load         : synchronous load of load_val (clamped to MOD-1)
//   load_val     : value for load
//   mode         : 00 up, 01 down, 10 ping-pong, 11 hold
//   flag_clr     : clears wrap_flag (a simultaneous tc wins)
//   q            : current count, 0..MOD-1
//   dir          : current direction, 0 = up, 1 = down
//   tc           : one-cycle registered terminal-count pulse
//   wrap_flag    : sticky, set by every tc
module mod_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MOD      = 16,
  parameter int unsigned      PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tc,
  output logic             wrap_flag
);
  import cnt_pkg::*;

  localparam logic [WIDTH-1:0] QMax   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] QMaxM1 = WIDTH'(MOD - 2);
  localparam logic [WIDTH-1:0] QOne   = WIDTH'(1);
  // One extra bit so MOD = 2^WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en && (mode != MODE_HOLD)),
    .sclr    (clear || load),
    .tick    (tick)
  );

  always_comb begin
    q_d    = q_q;
    dir_d  = dir_q;
    tc_d   = 1'b0;
    wrap_d = wrap_q;
    if (flag_clr) begin
      wrap_d = 1'b0;
    end

    if (clear) begin
      q_d    = '0;
      dir_d  = 1'b0;
      wrap_d = 1'b0;
    end else if (load) begin
      q_d = ({1'b0, load_val} >= ModExt) ? QMax : load_val;
    end else if (tick) begin
      unique case (mode)
        MODE_UP: begin
          dir_d = 1'b0;
          if (q_q == QMax) begin
            q_d  = '0;
            tc_d = 1'b1;
          end else begin
            q_d = q_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b1;
          if (q_q == '0) begin
            q_d  = QMax;
            tc_d = 1'b1;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
        MODE_PINGPONG: begin
          if (MOD == 2) begin
            // Two-state range: every tick is a turnaround.
            q_d   = (q_q == '0) ? QMax : '0;
            dir_d = (q_q == '0);
            tc_d  = 1'b1;
          end else if (!dir_q) begin
            if (q_q == QMax) begin
              // Parked at the top while heading up: turn without a pulse.
              q_d   = QMaxM1;
              dir_d = 1'b1;
            end else if (q_q == QMaxM1) begin
              q_d   = QMax;
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end else begin
              q_d = q_q + 1'b1;
            end
          end else begin
            if (q_q == '0) begin
              q_d   = QOne;
              dir_d = 1'b0;
            end else if (q_q == QOne) begin
              q_d   = '0;
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else begin
              q_d = q_q - 1'b1;
            end
          end
        end
        default: ; // hold never ticks; prescaler is frozen
      endcase
    end

    if (tc_d) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      dir_q  <= 1'b0;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      dir_q  <= dir_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign q         = q_q;
  assign dir       = dir_q;
  assign tc        = tc_q;
  assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter. Four instances share one stimulus:
//   u_a : WIDTH 4, MOD 10, PRESCALE 1
//   u_b : WIDTH 2, MOD 4,  PRESCALE 1
//   u_c : WIDTH 4, MOD 10, PRESCALE 3
//   u_d : WIDTH 1, MOD 2,  PRESCALE 1
// Each step pushes the expected state of one instance, clocks, then pops and
// compares it.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, clear, load, flag_clr;
  logic [3:0] load_val;
  logic [1:0] mode;

  logic [3:0] a_q, c_q;
  logic [1:0] b_q;
  logic [0:0] d_q;
  logic       a_dir, a_tc, a_wrap, b_dir, b_tc, b_wrap;
  logic       c_dir, c_tc, c_wrap, d_dir, d_tc, d_wrap;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MOD(10), .PRESCALE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .mode(mode), .flag_clr(flag_clr),
    .q(a_q), .dir(a_dir), .tc(a_tc), .wrap_flag(a_wrap)
  );

  mod_updown_counter #(.WIDTH(2), .MOD(4), .PRESCALE(1)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .load(load),
    .load_val(load_val[1:0]), .mode(mode), .flag_clr(flag_clr),
    .q(b_q), .dir(b_dir), .tc(b_tc), .wrap_flag(b_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MOD(10), .PRESCALE(3)) u_c (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .mode(mode), .flag_clr(flag_clr),
    .q(c_q), .dir(c_dir), .tc(c_tc), .wrap_flag(c_wrap)
  );

  mod_updown_counter #(.WIDTH(1), .MOD(2), .PRESCALE(1)) u_d (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .load(load),
    .load_val(load_val[0:0]), .mode(mode), .flag_clr(flag_clr),
    .q(d_q), .dir(d_dir), .tc(d_tc), .wrap_flag(d_wrap)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] q;
    logic        dir;
    logic        tc;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_now(input exp_t e);
    logic [31:0] oq;
    logic        od, ot, ow;
    case (e.sel)
      0:       begin oq = 32'(a_q); od = a_dir; ot = a_tc; ow = a_wrap; end
      1:       begin oq = 32'(b_q); od = b_dir; ot = b_tc; ow = b_wrap; end
      2:       begin oq = 32'(c_q); od = c_dir; ot = c_tc; ow = c_wrap; end
      default: begin oq = 32'(d_q); od = d_dir; ot = d_tc; ow = d_wrap; end
    endcase
    cmp({e.tag, ".q"},    oq,         e.q);
    cmp({e.tag, ".dir"},  32'(od),    32'(e.dir));
    cmp({e.tag, ".tc"},   32'(ot),    32'(e.tc));
    cmp({e.tag, ".wrap"}, 32'(ow),    32'(e.wrap));
  endtask

  function automatic exp_t mk(input string tag, input int sel, input int q,
                              input logic dir, input logic tc, input logic wrap);
    exp_t e;
    e.tag = tag; e.sel = sel; e.q = 32'(q); e.dir = dir; e.tc = tc; e.wrap = wrap;
    return e;
  endfunction

  // One clock: push expectation for the edge, clock, sample 1 time unit later.
  task automatic step(input string tag, input int sel, input int q,
                      input logic dir, input logic tc, input logic wrap);
    exp_t e;
    sb.push_back(mk(tag, sel, q, dir, tc, wrap));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_now(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0; clear = 1'b0; load = 1'b0; flag_clr = 1'b0;
    load_val = 4'd0; mode = 2'b00;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0; clear = 1'b0; load = 1'b0; flag_clr = 1'b0;
    load_val = 4'd0; mode = 2'b00;
    #3;
    check_now(mk("rst_a", 0, 0, 0, 0, 0));
    check_now(mk("rst_b", 1, 0, 0, 0, 0));
    check_now(mk("rst_c", 2, 0, 0, 0, 0));
    check_now(mk("rst_d", 3, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Up count with wrap at MOD-1 = 9.
    en = 1'b1; mode = 2'b00;
    for (int k = 1; k <= 11; k++) begin
      step($sformatf("up%0d", k), 0, k % 10, 1'b0, k == 10, k >= 10);
    end

    // Load clamp: 13 >= 10 gives 9; load beats a pending tick.
    load = 1'b1; load_val = 4'd13;
    step("load_clamp", 0, 9, 1'b0, 1'b0, 1'b1);
    load = 1'b0; mode = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      step($sformatf("down%0d", k), 0, 9 - k, 1'b1, 1'b0, 1'b1);
    end
    step("down_wrap", 0, 9, 1'b1, 1'b1, 1'b1);

    // Hold freezes q/dir; flag_clr drops the sticky flag.
    mode = 2'b11; flag_clr = 1'b1;
    step("hold_flagclr", 0, 9, 1'b1, 1'b0, 1'b0);
    flag_clr = 1'b0;
    step("hold", 0, 9, 1'b1, 1'b0, 1'b0);

    // Priority: clear over load over tick.
    mode = 2'b00;
    step("up_wrap2", 0, 0, 1'b0, 1'b1, 1'b1);
    clear = 1'b1; load = 1'b1; load_val = 4'd5;
    step("clr_prio", 0, 0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0; load_val = 4'd9;
    step("load9", 0, 9, 1'b0, 1'b0, 1'b0);
    load = 1'b0; flag_clr = 1'b1;
    step("flag_set_wins", 0, 0, 1'b0, 1'b1, 1'b1);
    flag_clr = 1'b0; en = 1'b0;
    step("en_off", 0, 0, 1'b0, 1'b0, 1'b1);

    // Async reset mid-count at q = 7.
    en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("pre_rst%0d", k), 0, k, 1'b0, 1'b0, 1'b1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_now(mk("async_rst", 0, 0, 0, 0, 0));
    #2;
    reset_n = 1'b1;
    step("post_rst", 0, 1, 1'b0, 1'b0, 1'b0);

    // Ping-pong, MOD = 4.
    do_reset();
    en = 1'b1; mode = 2'b10;
    step("pp1", 1, 1, 1'b0, 1'b0, 1'b0);
    step("pp2", 1, 2, 1'b0, 1'b0, 1'b0);
    step("pp3", 1, 3, 1'b1, 1'b1, 1'b1);
    step("pp4", 1, 2, 1'b1, 1'b0, 1'b1);
    step("pp5", 1, 1, 1'b1, 1'b0, 1'b1);
    step("pp6", 1, 0, 1'b0, 1'b1, 1'b1);
    step("pp7", 1, 1, 1'b0, 1'b0, 1'b1);
    // Loaded to the top while heading up: turn around without tc.
    load = 1'b1; load_val = 4'd3;
    step("pp_load", 1, 3, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    step("pp_turn", 1, 2, 1'b1, 1'b0, 1'b1);

    // Ping-pong, MOD = 2: tc on every tick.
    do_reset();
    en = 1'b1; mode = 2'b10;
    step("pp2_1", 3, 1, 1'b1, 1'b1, 1'b1);
    step("pp2_2", 3, 0, 1'b0, 1'b1, 1'b1);
    step("pp2_3", 3, 1, 1'b1, 1'b1, 1'b1);

    // Prescaler 3: ticks on cycles 3, 6, 9; en low for two cycles delays by two.
    do_reset();
    en = 1'b1; mode = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      step($sformatf("ps%0d", k), 2, k / 3, 1'b0, 1'b0, 1'b0);
    end
    step("ps10", 2, 3, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    step("ps_off1", 2, 3, 1'b0, 1'b0, 1'b0);
    step("ps_off2", 2, 3, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step("ps13", 2, 3, 1'b0, 1'b0, 1'b0);
    step("ps14", 2, 4, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Fully synchronous, parametrised successor to the 4-bit ripple counter. It provides a modulo-MOD counter of WIDTH bits with an enable and an integrated prescaler. It supports up, down, ping-pong and hold modes, synchronous clear, parallel load, a terminal-count pulse and a sticky wrap flag. It is used as the general-purpose event/timebase counter, and every bit changes on the single clk edge (no derived clocks).

Parameters:
WIDTH, 4, counter width in bits (1..32)
MOD, 16, count modulus; q ranges 0..MOD-1; legal 2 <= MOD <= 2^WIDTH
PRESCALE, 1, enabled clk cycles per count tick; legal 1..256 (1 = tick every enabled cycle)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
en  input  1  count enable; gates the prescaler and ticks
clear  input  1  synchronous clear of q, prescaler, dir and wrap_flag
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold
flag_clr  input  1  clears wrap_flag
q  output  WIDTH  current count
dir  output  1  current direction, 0 = up, 1 = down
tc  output  1  one-cycle terminal-count pulse (registered)
wrap_flag  output  1  sticky; set by any tc

Behaviour:
- Reset (reset_n = 0, asynchronous): q = 0, dir = 0, tc = 0, wrap_flag = 0, prescaler = 0. Release is sampled at the next clk edge.
- Priority per edge: clear > load > tick. flag_clr is independent of these.
- clear: q = 0, prescaler = 0, dir = 0, tc = 0, wrap_flag = 0. Applies regardless of en.
- load: q = load_val; if load_val >= MOD, q = MOD-1 (clamp). Prescaler = 0, tc = 0, dir unchanged. Applies regardless of en.
- Prescaler: counts 0..PRESCALE-1 only while en = 1 and mode != 11.
  - A tick occurs on the edge where prescaler == PRESCALE-1; the prescaler then returns to 0.
  - en = 0 or mode = 11 freezes the prescaler, and no tick occurs.
- Tick actions by mode:
  - up (00): dir = 0. q = q+1; if q == MOD-1, q = 0 and tc = 1.
  - down (01): dir = 1. q = q-1; if q == 0, q = MOD-1 and tc = 1.
  - ping-pong (10): steps in the direction held in dir.
    - When dir = 0 and q == MOD-2, q = MOD-1, dir = 1, tc = 1.
    - When dir = 1 and q == 1, q = 0, dir = 0, tc = 1.
    - If dir = 0 and q == MOD-1 (entered via load or a mode change), the next tick moves q to MOD-2 with dir = 1 and no tc; the mirror rule applies at 0.
    - For MOD = 2, q toggles 0/1 and tc asserts every tick.
  - hold (11): q, dir and prescaler are frozen; tc = 0.
- Mode change mid-count takes effect at the next tick. The prescaler phase is not reset. In up and down modes dir is updated to match the mode on each tick.
- tc is high for exactly one clk cycle, coincident with the q value produced by the wrap or turnaround. It is 0 on all other cycles.
- wrap_flag is set when tc is set. If flag_clr and a tc-setting tick occur on the same edge, set wins.
- Latency: q updates on the tick edge, with no extra pipeline stage. Without a prescaler, q reflects en one cycle later.
- Width: all arithmetic is WIDTH bits and never exceeds MOD-1, so there is no reliance on natural 2^WIDTH wrap unless MOD = 2^WIDTH.

Decomposition:
- Shared package cnt_pkg holds:
  - mode encodings MODE_UP = 2'b00, MODE_DOWN = 2'b01, MODE_PINGPONG = 2'b10, MODE_HOLD = 2'b11
  - a clog2-based prescaler width function
- One sub-module, tick_prescaler. Parameter PRESCALE; ports clk, reset_n, en, sclr; output tick. It sits beside the counter/direction FSM in mod_updown_counter.

Test Plan:
- Reset and up-wrap (WIDTH = 4, MOD = 10, PRESCALE = 1), en = 1, mode = 00 for 12 cycles -> q = 0,1..9,0,1; tc high only in the cycle q = 0 after 9; wrap_flag = 1 thereafter.
- Down and load clamp: load with load_val = 13 (MOD = 10) -> q = 9. Then mode = 01 for 10 ticks -> q counts 8..0, then 9 with tc = 1.
- Ping-pong (MOD = 4): from q = 0, dir = 0 -> q = 1,2,3(tc, dir = 1),2,1,0(tc, dir = 0),1.
- Prescaler (PRESCALE = 3, mode = 00): en = 1 for 9 cycles -> q increments at cycles 3, 6 and 9 only. Dropping en for 2 cycles mid-phase delays the next tick by 2 cycles.
- Priority: clear, load (load_val = 5) and a tick on the same edge -> q = 0, wrap_flag = 0. Then flag_clr together with a wrap tick -> wrap_flag stays 1.
- Async reset mid-count: assert reset_n = 0 between edges at q = 7 -> q = 0, dir = 0, tc = 0 immediately. After release, the first tick gives q = 1.
